or1200_if_bus_arb: RTL and testbench

- Arbitrates the single instruction-memory port (icpu-style cycstb/ack/err/tag bus) between the fetch unit (IF) and the debug unit's instruction-memory access port (DBG).
- Sequences one transaction at a time and latches the winning address.
- Forwards responses only to the owning requester.
- Enforces debug anti-starvation and a bus watchdog that synthesises a bus-error tag.

---
 rtl/or1200_if_bus_arb_if.sv | 48 ++++
 rtl/or1200_if_bus_arb.sv | 115 +++++++++++
 tb/tb_or1200_if_bus_arb.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/or1200_if_bus_arb_if.sv
// Bundle of the fetch, debug and instruction-memory signals around the
// instruction-bus arbiter; the arbiter takes the slave view.
interface or1200_if_bus_arb_if;
    // fetch unit side
    logic        if_cycstb_i;
    logic [31:0] if_adr_i;
    logic        if_flush_i;
    logic        if_ack_o;
    logic        if_err_o;
    logic [31:0] if_dat_o;
    logic [3:0]  if_tag_o;
    // debug unit side
    logic        dbg_cycstb_i;
    logic [31:0] dbg_adr_i;
    logic        dbg_ack_o;
    logic        dbg_err_o;
    logic [31:0] dbg_dat_o;
    // memory side
    logic        mem_cycstb_o;
    logic [31:0] mem_adr_o;
    logic        mem_ack_i;
    logic        mem_err_i;
    logic [31:0] mem_dat_i;
    logic [3:0]  mem_tag_i;
    // status
    logic [1:0]  grant_o;
    logic        timeout_o;

    modport slave (
        input  if_cycstb_i, if_adr_i, if_flush_i,
        output if_ack_o, if_err_o, if_dat_o, if_tag_o,
        input  dbg_cycstb_i, dbg_adr_i,
        output dbg_ack_o, dbg_err_o, dbg_dat_o,
        output mem_cycstb_o, mem_adr_o,
        input  mem_ack_i, mem_err_i, mem_dat_i, mem_tag_i,
        output grant_o, timeout_o
    );

    modport master (
        output if_cycstb_i, if_adr_i, if_flush_i,
        input  if_ack_o, if_err_o, if_dat_o, if_tag_o,
        output dbg_cycstb_i, dbg_adr_i,
        input  dbg_ack_o, dbg_err_o, dbg_dat_o,
        input  mem_cycstb_o, mem_adr_o,
        output mem_ack_i, mem_err_i, mem_dat_i, mem_tag_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/or1200_if_bus_arb.sv
// Shares one instruction-memory port between fetch and debug: one transaction
// at a time, debug anti-starvation, and a watchdog that fakes a bus error.
module or1200_if_bus_arb #(
    parameter int unsigned MAX_IF_BURST = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    or1200_if_bus_arb_if.slave         bus
);
    localparam logic [31:0] NOP       = 32'h1441_0000;
    localparam logic [3:0]  TMO_TAG   = 4'hb;
    localparam logic [3:0]  BURST_MAX = 4'(MAX_IF_BURST);
    localparam logic [7:0]  WD_LAST   = 8'(TIMEOUT - 1);
    localparam bit          WD_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DBG} state_t;

    state_t      state;
    logic [3:0]  starv_cnt;
    logic [7:0]  wd_cnt;
    logic        drop;
    logic [1:0]  grant;
    logic        mem_cycstb;
    logic [31:0] mem_adr;

    logic if_req, dbg_req, pick_if, pick_dbg;
    logic busy_if, busy_dbg, busy;
    logic owner_abort, fwd, expiry, done, ack, err;

    // A flushed fetch is not a candidate, even if cycstb is still high.
    assign if_req   = bus.if_cycstb_i & ~bus.if_flush_i;
    assign dbg_req  = bus.dbg_cycstb_i;
    assign pick_dbg = dbg_req & (~if_req | (starv_cnt == BURST_MAX));
    assign pick_if  = if_req & ~pick_dbg;

    assign busy_if  = (state == BUSY_IF);
    assign busy_dbg = (state == BUSY_DBG);
    assign busy     = busy_if | busy_dbg;

    // Abandonment in the current cycle already blocks forwarding, so a flush
    // coinciding with the ack never leaks a stale instruction.
    assign owner_abort = busy_if  ? (bus.if_flush_i | ~bus.if_cycstb_i)
                                  : (busy_dbg & ~bus.dbg_cycstb_i);
    assign fwd    = busy & ~drop & ~owner_abort;
    assign expiry = WD_EN & busy & (wd_cnt == WD_LAST) & ~bus.mem_ack_i & ~bus.mem_err_i;
    assign done   = busy & (bus.mem_ack_i | bus.mem_err_i | expiry);
    assign ack    = fwd & bus.mem_ack_i & ~bus.mem_err_i;
    assign err    = fwd & (bus.mem_err_i | expiry);

    assign bus.if_ack_o  = busy_if & ack;
    assign bus.if_err_o  = busy_if & err;
    assign bus.if_tag_o  = (busy_if & err) ? (bus.mem_err_i ? bus.mem_tag_i : TMO_TAG) : 4'h0;
    assign bus.if_dat_o  = (busy_if & ack) ? bus.mem_dat_i : NOP;

    assign bus.dbg_ack_o = busy_dbg & ack;
    assign bus.dbg_err_o = busy_dbg & err;
    assign bus.dbg_dat_o = (busy_dbg & ack) ? bus.mem_dat_i : 32'h0;

    assign bus.mem_cycstb_o = mem_cycstb;
    assign bus.mem_adr_o    = mem_adr;
    assign bus.grant_o      = grant;
    assign bus.timeout_o    = expiry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starv_cnt  <= 4'h0;
            wd_cnt     <= 8'h0;
            drop       <= 1'b0;
            grant      <= 2'b00;
            mem_cycstb <= 1'b0;
            mem_adr    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (pick_dbg) begin
                        state      <= BUSY_DBG;
                        grant      <= 2'b10;
                        mem_cycstb <= 1'b1;
                        mem_adr    <= bus.dbg_adr_i & ~32'h3;
                        wd_cnt     <= 8'h0;
                        starv_cnt  <= 4'h0;
                    end else if (pick_if) begin
                        state      <= BUSY_IF;
                        grant      <= 2'b01;
                        mem_cycstb <= 1'b1;
                        mem_adr    <= bus.if_adr_i & ~32'h3;
                        wd_cnt     <= 8'h0;
                        // Only grants that pass over a waiting debug request count.
                        if (!dbg_req)
                            starv_cnt <= 4'h0;
                        else if (starv_cnt != BURST_MAX)
                            starv_cnt <= starv_cnt + 4'd1;
                    end else if (!dbg_req) begin
                        starv_cnt <= 4'h0;
                    end
                end
                BUSY_IF, BUSY_DBG: begin
                    if (wd_cnt != 8'hff)
                        wd_cnt <= wd_cnt + 8'd1;
                    if (owner_abort)
                        drop <= 1'b1;
                    if (done) begin
                        state      <= IDLE;
                        grant      <= 2'b00;
                        mem_cycstb <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_or1200_if_bus_arb.sv
// Scoreboard bench for the instruction-bus arbiter: a transaction-level model
// predicts grants and responses, a negedge monitor compares what the DUT shows.
module tb_or1200_if_bus_arb;
    localparam int          MAXB = 4;
    localparam int          TMO  = 16;
    localparam logic [31:0] NOP  = 32'h1441_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    or1200_if_bus_arb_if bus ();
    or1200_if_bus_arb #(.MAX_IF_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] adr;
    } gexp_t;

    typedef struct packed {
        logic        if_ack;
        logic        if_err;
        logic [3:0]  tag;
        logic [31:0] if_dat;
        logic        dbg_ack;
        logic        dbg_err;
        logic [31:0] dbg_dat;
        logic        tmo;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    logic [1:0]  prev_grant = 2'b00;
    logic [31:0] cur_adr = 32'h0;

    // requester state held by the model
    bit          pend_if = 1'b0, pend_dbg = 1'b0;
    logic [31:0] a_if = 32'h0, a_dbg = 32'h0;
    int          streak = 0;   // IF grants in a row that passed over a waiting DBG

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic rexp_t quiet();
        rexp_t q;
        q = '0;
        q.if_dat = NOP;
        return q;
    endfunction

    always @(negedge clk) begin : mon
        rexp_t act, e;
        gexp_t g;
        if (mon_en) begin
            act = {bus.if_ack_o, bus.if_err_o, bus.if_tag_o, bus.if_dat_o,
                   bus.dbg_ack_o, bus.dbg_err_o, bus.dbg_dat_o, bus.timeout_o};
            if (bus.grant_o != 2'b00 && prev_grant == 2'b00) begin
                if (gq.size() == 0)
                    chk("unexpected_grant", 80'(bus.grant_o), 80'd0);
                else begin
                    g = gq.pop_front();
                    cur_adr = g.adr;
                    chk("grant", {bus.grant_o, bus.mem_adr_o}, g);
                end
            end
            if (bus.grant_o != 2'b00)
                chk("busy_bus", {bus.mem_cycstb_o, bus.mem_adr_o}, {1'b1, cur_adr});
            else
                chk("idle_cycstb", 80'(bus.mem_cycstb_o), 80'd0);
            if (act.if_ack | act.if_err | act.dbg_ack | act.dbg_err | act.tmo) begin
                if (rq.size() == 0)
                    chk("unexpected_resp", act, quiet());
                else begin
                    e = rq.pop_front();
                    chk("resp", act, e);
                end
            end else
                chk("quiet", act, quiet());
            prev_grant = bus.grant_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One arbitration cycle plus, if something wins, its whole transaction.
    // lat: BUSY cycle of the memory response (beyond TMO means watchdog).
    task automatic txn(input int lat, input bit e_err, input bit e_ack, input int drop_at,
                       input bit idle_flush, input bit stray, input int rst_at);
        int          win;
        bit          if_elig, dropped;
        rexp_t       r;
        gexp_t       g;
        logic [31:0] d;
        logic [3:0]  t;
        bus.if_cycstb_i  = pend_if;
        bus.if_adr_i     = a_if;
        bus.dbg_cycstb_i = pend_dbg;
        bus.dbg_adr_i    = a_dbg;
        bus.if_flush_i   = idle_flush & pend_if;
        bus.mem_ack_i    = stray;
        bus.mem_err_i    = 1'b0;
        if_elig = pend_if & !bus.if_flush_i;
        // IF is preferred unless DBG has already been passed over MAXB times
        if (if_elig && pend_dbg) win = (streak >= MAXB) ? 2 : 1;
        else if (if_elig)        win = 1;
        else if (pend_dbg)       win = 2;
        else                     win = 0;
        if (!pend_dbg || win == 2) streak = 0;
        else if (win == 1 && streak < MAXB) streak++;
        if (win != 0) begin
            g.grant = (win == 1) ? 2'b01 : 2'b10;
            g.adr   = ((win == 1) ? a_if : a_dbg) & ~32'h3;
            gq.push_back(g);
        end
        tick();
        bus.if_flush_i = 1'b0;
        bus.mem_ack_i  = 1'b0;
        if (win == 0) return;
        dropped = 1'b0;
        for (int c = 1; c < 1000; c++) begin
            bus.mem_ack_i = 1'b0;
            bus.mem_err_i = 1'b0;
            if (c == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                streak = 0;
                return;
            end
            if (c == drop_at) begin
                dropped = 1'b1;
                if (win == 1) begin
                    bus.if_flush_i  = 1'b1;
                    bus.if_cycstb_i = 1'b0;
                end else
                    bus.dbg_cycstb_i = 1'b0;
            end else
                bus.if_flush_i = 1'b0;
            d = $urandom;
            t = 4'($urandom);
            bus.mem_dat_i = d;
            bus.mem_tag_i = t;
            if (c == lat) begin
                bus.mem_ack_i = e_ack | !e_err;
                bus.mem_err_i = e_err;
                if (!dropped) begin
                    r = quiet();
                    if (win == 1) begin
                        r.if_ack = !e_err;
                        r.if_err = e_err;
                        r.tag    = e_err ? t : 4'h0;
                        if (!e_err) r.if_dat = d;
                    end else begin
                        r.dbg_ack = !e_err;
                        r.dbg_err = e_err;
                        if (!e_err) r.dbg_dat = d;
                    end
                    rq.push_back(r);
                end
                tick();
                break;
            end
            if (TMO != 0 && c == TMO) begin
                r = quiet();
                r.tmo = 1'b1;
                if (!dropped) begin
                    if (win == 1) begin
                        r.if_err = 1'b1;
                        r.tag    = 4'hb;
                    end else
                        r.dbg_err = 1'b1;
                end
                rq.push_back(r);
                tick();
                break;
            end
            tick();
        end
        bus.mem_ack_i  = 1'b0;
        bus.mem_err_i  = 1'b0;
        bus.if_flush_i = 1'b0;
        if (win == 1) begin
            pend_if = 1'b0;
            bus.if_cycstb_i = 1'b0;
        end else begin
            pend_dbg = 1'b0;
            bus.dbg_cycstb_i = 1'b0;
        end
    endtask

    initial begin
        int r;
        int lat;
        bus.if_cycstb_i = 0; bus.if_adr_i = 0; bus.if_flush_i = 0;
        bus.dbg_cycstb_i = 0; bus.dbg_adr_i = 0;
        bus.mem_ack_i = 0; bus.mem_err_i = 0; bus.mem_dat_i = 0; bus.mem_tag_i = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_state", {bus.grant_o, bus.mem_cycstb_o, bus.mem_adr_o, bus.timeout_o}, 80'd0);
        mon_en = 1'b1;

        // zero-wait fetch, unaligned address
        pend_if = 1; a_if = 32'h0000_0103;
        txn(1, 0, 0, 0, 0, 0, 0);
        // both requesters continuously asserted
        for (int k = 0; k < 12; k++) begin
            if (!pend_if)  begin pend_if = 1;  a_if = $urandom;  end
            if (!pend_dbg) begin pend_dbg = 1; a_dbg = $urandom; end
            txn(1, 0, 0, 0, 0, 0, 0);
        end
        // flush during a slow fetch while DBG waits
        pend_if = 1; a_if = 32'h0000_2000; pend_dbg = 1; a_dbg = 32'h0000_3001;
        txn(4, 0, 0, 1, 0, 0, 0);
        txn(1, 0, 0, 0, 0, 0, 0);
        // error beats ack
        pend_if = 1; a_if = 32'h0000_0040;
        txn(1, 1, 1, 0, 0, 0, 0);
        // watchdog on DBG, then a stray ack two cycles later
        pend_dbg = 1; a_dbg = 32'h0000_8000;
        txn(TMO + 3, 0, 0, 0, 0, 0, 0);
        txn(1, 0, 0, 0, 0, 0, 0);
        txn(1, 0, 0, 0, 0, 1, 0);

        for (int k = 0; k < 300; k++) begin
            if (!pend_if && ($urandom % 2 == 0))   begin pend_if = 1;  a_if = $urandom;  end
            if (!pend_dbg && ($urandom % 5 < 2))   begin pend_dbg = 1; a_dbg = $urandom; end
            r   = $urandom % 10;
            lat = (r < 7) ? 1 + $urandom % 4 : 1 + $urandom % (TMO + 4);
            txn(lat, ($urandom % 6 == 0), $urandom % 2,
                ($urandom % 8 == 0) ? 1 + $urandom % 4 : 0,
                ($urandom % 8 == 0), ($urandom % 5 == 0), 0);
        end

        // build up the starvation count, then reset in the middle of an IF transaction
        for (int k = 0; k < 10 && streak != 3; k++) begin
            if (!pend_if)  begin pend_if = 1;  a_if = $urandom;  end
            if (!pend_dbg) begin pend_dbg = 1; a_dbg = $urandom; end
            txn(1, 0, 0, 0, 0, 0, 0);
        end
        if (!pend_if)  begin pend_if = 1;  a_if = $urandom;  end
        if (!pend_dbg) begin pend_dbg = 1; a_dbg = $urandom; end
        txn(TMO + 3, 0, 0, 0, 0, 0, 3);
        chk("rst_mid_grant", 80'(bus.grant_o), 80'd0);
        chk("rst_mid_cycstb", 80'(bus.mem_cycstb_o), 80'd0);
        chk("rst_mid_adr", 80'(bus.mem_adr_o), 80'd0);
        // cleared starvation count means IF wins this tie
        txn(1, 0, 0, 0, 0, 0, 0);
        txn(2, 0, 0, 0, 0, 0, 0);

        repeat (4) tick();
        chk("grant_queue_empty", 80'(gq.size()), 80'd0);
        chk("resp_queue_empty", 80'(rq.size()), 80'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
